// File: rtl/mod_square_gen.sv
`default_nettype none
// ============================================================================
// Module   : mod_square_gen
// Purpose  : Square-wave modulation generator for a DAC. It alternates between
//            a high half and a low half of programmable length, emits a
//            status level and a one-clock trigger at every half boundary for
//            a downstream demodulator, and optionally adds a slow phase ramp
//            on top of the square levels.
//
// Ports    : i_clk          - single clock for all logic
//            i_rst_n        - synchronous active-low reset
//            i_en           - modulation run enable
//            i_half_period  - half-period length in clocks (values < 2 act as 2)
//            i_amp_h        - signed DAC level for the high half
//            i_amp_l        - signed DAC level for the low half
//            i_step         - ramp phase increment applied once per full period
//            o_mod          - registered signed DAC modulation code
//            o_status       - high during the high half
//            o_trig         - one-clock pulse on every half boundary
//            o_ramp         - 32-bit ramp phase accumulator (2^32 == 2 pi)
//
// Build    : define MOD_RAMP_EN to compile in the phase ramp. Without it
//            o_ramp is tied to 0, i_step is ignored and o_mod carries the
//            plain square levels.
//
// Revision : 1.0 - initial release
// ============================================================================
module mod_square_gen #(
    parameter int DAC_W = 16,
    parameter int CNT_W = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_en,
    input  logic [CNT_W-1:0]        i_half_period,
    input  logic signed [DAC_W-1:0] i_amp_h,
    input  logic signed [DAC_W-1:0] i_amp_l,
    input  logic signed [31:0]      i_step,
    output logic signed [DAC_W-1:0] o_mod,
    output logic                    o_status,
    output logic                    o_trig,
    output logic [31:0]             o_ramp
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [CNT_W-1:0] c_HP_MIN = CNT_W'(2);
    localparam logic [CNT_W-1:0] c_ONE    = CNT_W'(1);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Registers and their next-state values
    // ------------------------------------------------------------------------
    state_t                  r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        r_hp;       // shadow half-period for this period
    logic signed [DAC_W-1:0] r_mod;
    logic                    r_status;
    logic                    r_trig;

    state_t                  w_state_nxt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic [CNT_W-1:0]        w_hp_nxt;
    logic signed [DAC_W-1:0] w_mod_nxt;
    logic                    w_status_nxt;
    logic                    w_trig_nxt;

    // Level to load on entry to each half (ramp already folded in if enabled)
    logic signed [DAC_W-1:0] w_mod_h;
    logic signed [DAC_W-1:0] w_mod_l;

    logic [CNT_W-1:0]        w_hp_in;
    logic                    w_last;

    // A half-period shorter than 2 clocks would make the trigger and status
    // indistinguishable, so the requested length is clamped up to 2.
    assign w_hp_in = (i_half_period < c_HP_MIN) ? c_HP_MIN : i_half_period;

    // Final clock of the current half.
    assign w_last  = (r_cnt == (r_hp - c_ONE));

`ifdef MOD_RAMP_EN
    // ------------------------------------------------------------------------
    // Phase ramp
    // ------------------------------------------------------------------------
    logic [31:0] r_ramp;
    logic [31:0] w_ramp_add;
    logic [31:0] w_ramp_hi;
    logic        w_ramp_adv;

    // Signed add of two DAC_W-bit values with clipping to the DAC range.
    function automatic logic signed [DAC_W-1:0] sat_add(
        input logic signed [DAC_W-1:0] a,
        input logic signed [DAC_W-1:0] b
    );
        logic [DAC_W:0] s;
        s = {a[DAC_W-1], a} + {b[DAC_W-1], b};
        // Overflow shows as disagreement between the two top bits of the
        // one-bit-wider sum; the extra MSB holds the true sign.
        if (s[DAC_W] != s[DAC_W-1]) begin
            if (s[DAC_W]) begin
                sat_add = {1'b1, {(DAC_W-1){1'b0}}};
            end else begin
                sat_add = {1'b0, {(DAC_W-1){1'b1}}};
            end
        end else begin
            sat_add = s[DAC_W-1:0];
        end
    endfunction

    // The ramp advances only on a LOW -> HIGH boundary (a full period), not on
    // the first HIGH entry from IDLE, and not when the enable drops.
    assign w_ramp_adv = (r_state == LOW) && i_en && w_last;
    assign w_ramp_add = r_ramp + i_step;

    // The high level is built from the ramp value that becomes visible in the
    // same clock, so o_mod and o_ramp always agree.
    assign w_ramp_hi  = w_ramp_adv ? w_ramp_add : r_ramp;

    assign w_mod_h    = sat_add(i_amp_h, w_ramp_hi[31 -: DAC_W]);
    assign w_mod_l    = sat_add(i_amp_l, r_ramp[31 -: DAC_W]);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ramp <= 32'd0;
        end else if (w_ramp_adv) begin
            r_ramp <= w_ramp_add;   // wraps modulo 2^32
        end
    end

    assign o_ramp = r_ramp;
`else
    // ------------------------------------------------------------------------
    // Ramp not built: plain square levels, step input unused.
    // ------------------------------------------------------------------------
    logic w_unused_step;

    assign w_unused_step = ^i_step;
    assign w_mod_h       = i_amp_h;
    assign w_mod_l       = i_amp_l;
    assign o_ramp        = 32'd0;
`endif

    // ------------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt + c_ONE;
        w_hp_nxt     = r_hp;
        w_mod_nxt    = r_mod;
        w_status_nxt = r_status;
        w_trig_nxt   = 1'b0;

        case (r_state)
            IDLE: begin
                w_cnt_nxt    = '0;
                w_mod_nxt    = '0;
                w_status_nxt = 1'b0;
                if (i_en) begin
                    w_state_nxt  = HIGH;
                    w_hp_nxt     = w_hp_in;
                    w_mod_nxt    = w_mod_h;
                    w_status_nxt = 1'b1;
                    w_trig_nxt   = 1'b1;
                end
            end

            HIGH: begin
                // Enable drop wins over a coincident boundary: no trigger.
                if (!i_en) begin
                    w_state_nxt  = IDLE;
                    w_cnt_nxt    = '0;
                    w_mod_nxt    = '0;
                    w_status_nxt = 1'b0;
                end else if (w_last) begin
                    w_state_nxt  = LOW;
                    w_cnt_nxt    = '0;
                    w_mod_nxt    = w_mod_l;
                    w_status_nxt = 1'b0;
                    w_trig_nxt   = 1'b1;
                end
            end

            LOW: begin
                if (!i_en) begin
                    w_state_nxt  = IDLE;
                    w_cnt_nxt    = '0;
                    w_mod_nxt    = '0;
                    w_status_nxt = 1'b0;
                end else if (w_last) begin
                    // Period boundary: the new half-period takes effect here.
                    w_state_nxt  = HIGH;
                    w_cnt_nxt    = '0;
                    w_hp_nxt     = w_hp_in;
                    w_mod_nxt    = w_mod_h;
                    w_status_nxt = 1'b1;
                    w_trig_nxt   = 1'b1;
                end
            end

            default: begin
                w_state_nxt  = IDLE;
                w_cnt_nxt    = '0;
                w_mod_nxt    = '0;
                w_status_nxt = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_hp     <= c_HP_MIN;
            r_mod    <= '0;
            r_status <= 1'b0;
            r_trig   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_hp     <= w_hp_nxt;
            r_mod    <= w_mod_nxt;
            r_status <= w_status_nxt;
            r_trig   <= w_trig_nxt;
        end
    end

    assign o_mod    = r_mod;
    assign o_status = r_status;
    assign o_trig   = r_trig;

endmodule
`default_nettype wire

// File: tb/tb_mod_square_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_mod_square_gen
// Purpose  : Directed self-checking bench for mod_square_gen. Expected values
//            are hand-derived from the required behaviour; the ramp cases are
//            selected by the same MOD_RAMP_EN macro as the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mod_square_gen;

    localparam int DAC_W = 16;
    localparam int CNT_W = 32;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    en;
    logic [CNT_W-1:0]        half_period;
    logic signed [DAC_W-1:0] amp_h;
    logic signed [DAC_W-1:0] amp_l;
    logic signed [31:0]      step;
    logic signed [DAC_W-1:0] mod;
    logic                    status;
    logic                    trig;
    logic [31:0]             ramp;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mod_square_gen #(
        .DAC_W (DAC_W),
        .CNT_W (CNT_W)
    ) u_dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_en          (en),
        .i_half_period (half_period),
        .i_amp_h       (amp_h),
        .i_amp_l       (amp_l),
        .i_step        (step),
        .o_mod         (mod),
        .o_status      (status),
        .o_trig        (trig),
        .o_ramp        (ramp)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " status"}, status, 1'b0);
        check({tag, " trig"},   trig,   1'b0);
        check({tag, " mod"},    mod,    0);
    endtask

    initial begin
        rst_n       = 1'b0;
        en          = 1'b1;     // reset must override a live enable
        half_period = 5;
        amp_h       = 1000;
        amp_l       = -1000;
`ifdef MOD_RAMP_EN
        step        = 32'sd0;
`else
        step        = 32'sh4000_0000;   // must have no effect in this build
`endif

        // ---------------- reset state ----------------
        tick();
        tick();
        check_idle("reset");
        check("reset ramp", ramp, 32'd0);

        // ---------------- 5/5 square, +1000/-1000 ----------------
        rst_n = 1'b1;
        tick();                                     // k = 0: first HIGH cycle
        for (int k = 0; k < 20; k++) begin
            check($sformatf("sq5 status k=%0d", k), status, ((k % 10) < 5) ? 1'b1 : 1'b0);
            check($sformatf("sq5 trig k=%0d", k),   trig,   ((k % 5) == 0) ? 1'b1 : 1'b0);
            check($sformatf("sq5 mod k=%0d", k),    mod,    ((k % 10) < 5) ? 1000 : -1000);
`ifndef MOD_RAMP_EN
            check($sformatf("sq5 ramp k=%0d", k),   ramp,   32'd0);
`endif
            tick();
        end

        // ---------------- enable drop on the boundary clock ----------------
        repeat (4) tick();                          // k = 24: last HIGH cycle
        check("pre-drop status", status, 1'b1);
        en = 1'b0;
        tick();
        check_idle("drop");
        tick();
        check_idle("drop+1");

        // ---------------- half_period = 0 clamps to 2 ----------------
        half_period = 0;
        en          = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) begin
            check($sformatf("hp0 status k=%0d", k), status, ((k % 4) < 2) ? 1'b1 : 1'b0);
            check($sformatf("hp0 trig k=%0d", k),   trig,   ((k % 2) == 0) ? 1'b1 : 1'b0);
            tick();
        end

        // ---------------- mid-period change 5 -> 3 ----------------
        en = 1'b0;
        tick();
        check_idle("idle before hp change");
        half_period = 5;
        en          = 1'b1;
        tick();
        for (int k = 0; k < 16; k++) begin
            logic exp_s;
            logic exp_t;
            if (k < 5)       exp_s = 1'b1;
            else if (k < 10) exp_s = 1'b0;
            else             exp_s = (((k - 10) % 6) < 3) ? 1'b1 : 1'b0;
            exp_t = (k == 0) || (k == 5) || (k == 10) || (k == 13);
            check($sformatf("hpchg status k=%0d", k), status, exp_s);
            check($sformatf("hpchg trig k=%0d", k),   trig,   exp_t);
            if (k == 1) half_period = 3;
            tick();
        end

        // ---------------- reset aborts a half on its boundary ----------------
        tick();
        tick();                                     // last cycle of a 3-long HIGH
        check("pre-reset status", status, 1'b1);
        rst_n = 1'b0;
        tick();
        check_idle("abort");
        check("abort ramp", ramp, 32'd0);
        en = 1'b0;
        tick();
        rst_n = 1'b1;

`ifdef MOD_RAMP_EN
        // ---------------- ramp wrap over four periods ----------------
        begin
            logic [31:0] exp_ramp [4];
            int          exp_mod  [4];
            exp_ramp = '{32'h4000_0000, 32'h8000_0000, 32'hC000_0000, 32'h0000_0000};
            exp_mod  = '{16384, -32768, -16384, 0};
            half_period = 2;
            amp_h       = 0;
            amp_l       = 0;
            step        = 32'sh4000_0000;
            en          = 1'b1;
            tick();
            check("ramp start", ramp, 32'd0);
            check("ramp start mod", mod, 0);
            for (int p = 0; p < 4; p++) begin
                repeat (2) tick();                  // LOW half
                check($sformatf("ramp low mod p=%0d", p), mod, (p == 0) ? 0 : exp_mod[p-1]);
                repeat (2) tick();                  // next HIGH entry
                check($sformatf("ramp val p=%0d", p), ramp, exp_ramp[p]);
                check($sformatf("ramp mod p=%0d", p), mod,  exp_mod[p]);
            end
            en = 1'b0;
            tick();
            check_idle("ramp idle");
        end

        // ---------------- positive saturation ----------------
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        step  = 32'sh1000_0000;
        amp_h = 32000;
        amp_l = 0;
        en    = 1'b1;
        tick();
        check("sat k0 mod", mod, 32000);
        repeat (2) tick();
        check("sat k2 mod", mod, 0);
        repeat (2) tick();
        check("sat k4 ramp", ramp, 32'h1000_0000);
        check("sat k4 mod", mod, 32767);
        repeat (2) tick();
        check("sat k6 mod", mod, 4096);
`else
        // ---------------- ramp not built: levels only ----------------
        half_period = 2;
        amp_h       = 123;
        amp_l       = -77;
        en          = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) begin
            check($sformatf("noramp mod k=%0d", k),  mod,  ((k % 4) < 2) ? 123 : -77);
            check($sformatf("noramp ramp k=%0d", k), ramp, 32'd0);
            tick();
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mod_square_gen.md
MOD_SQUARE_GEN -- requirements
Module: mod_square_gen

Interface
REQ-001 The module SHALL have parameter DAC_W, default 16, giving the signed width of the DAC modulation output.
REQ-002 The module SHALL have parameter CNT_W, default 32, giving the width of the half-period counter.
REQ-003 The module SHALL have port i_clk, input, 1, the single clock for all logic.
REQ-004 The module SHALL have port i_rst_n, input, 1, synchronous active-low reset.
REQ-005 The module SHALL have port i_en, input, 1, the modulation run enable.
REQ-006 The module SHALL have port i_half_period, input, CNT_W, the half-period length in clocks.
REQ-007 The module SHALL have port i_amp_h, input, signed DAC_W, the DAC level for the high half.
REQ-008 The module SHALL have port i_amp_l, input, signed DAC_W, the DAC level for the low half.
REQ-009 The module SHALL have port i_step, input, signed 32, the ramp phase increment per full period.
REQ-010 The module SHALL have port o_mod, output, signed DAC_W, the registered DAC modulation code.
REQ-011 The module SHALL have port o_status, output, 1, high during the high half, for the demodulator's status input.
REQ-012 The module SHALL have port o_trig, output, 1, a one-clock pulse at every half-period boundary, for the demodulator's trigger input.
REQ-013 The module SHALL have port o_ramp, output, 32, the ramp phase accumulator value.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, HIGH and LOW.
REQ-015 In IDLE with i_en=1, the next clock SHALL enter HIGH, clear the counter to 0, set o_status=1, pulse o_trig=1 and load o_mod from the high level.
REQ-016 In HIGH, the counter SHALL increment each clock; when the counter equals hp-1, the next clock SHALL enter LOW with counter=0, o_status=0, o_trig=1 and o_mod from the low level.
REQ-017 In LOW, when the counter equals hp-1, the next clock SHALL enter HIGH with the same updates as REQ-015, which is the period boundary.
REQ-018 hp SHALL be a shadow copy of i_half_period, latched only on entry to HIGH from IDLE or LOW; changes mid-period SHALL take effect at the next period boundary.
REQ-019 If i_half_period < 2, hp SHALL be clamped to 2.
REQ-020 i_amp_h and i_amp_l SHALL be sampled on the clock of each transition into HIGH and LOW respectively, and held constant within a half.
REQ-021 o_trig SHALL be high for exactly one clock per transition, coincident with the first cycle of the new o_status value; o_trig SHALL be 0 at all other times.
REQ-022 o_status, o_trig and o_mod SHALL be registered, with no combinational path from any input.
REQ-023 Deassertion of i_en in HIGH or LOW SHALL cause IDLE on the next clock with o_mod=0, o_status=0, o_trig=0 and counter=0; the ramp SHALL hold its value.
REQ-024 Simultaneous i_en deassertion and half boundary SHALL give IDLE, and o_trig SHALL NOT pulse.

Reset
REQ-025 With i_rst_n=0 at a clock edge, the module SHALL enter IDLE with counter=0, hp=2, o_mod=0, o_status=0, o_trig=0 and o_ramp=0.
REQ-026 Reset SHALL override i_en and abort any half in progress, with no trig pulse emitted.

Configuration
REQ-027 The macro MOD_RAMP_EN SHALL select whether the phase ramp is compiled in.
REQ-028 With MOD_RAMP_EN defined, o_ramp SHALL add i_step at each HIGH entry from LOW, wrapping modulo 2^32 (2 pi).
REQ-029 With MOD_RAMP_EN defined, o_mod SHALL equal the level plus o_ramp[31:32-DAC_W] in signed arithmetic, saturated to the DAC_W signed range.
REQ-030 Without MOD_RAMP_EN, o_ramp SHALL be constant 0, i_step SHALL be ignored and o_mod SHALL equal the level only.

Verification
REQ-031 The bench SHALL apply i_half_period=5, amp_h=1000, amp_l=-1000, i_en=1 -> required response: o_status alternates 5 high/5 low, o_trig pulses every 5 clocks, and o_mod=+1000/-1000.
REQ-032 The bench SHALL apply i_half_period=0 -> required response: hp clamps to 2, giving o_status toggling every 2 clocks.
REQ-033 The bench SHALL change i_half_period from 5 to 3 at the 2nd clock of HIGH -> required response: the current period stays 5+5, and the next period is 3+3.
REQ-034 The bench SHALL drop i_en on the boundary clock -> required response: IDLE next clock, o_mod=0, and no o_trig pulse.
REQ-035 The bench SHALL, with MOD_RAMP_EN, apply i_step=0x4000_0000 and amp_h=amp_l=0 -> required response: o_ramp = 0x40000000, 0x80000000, 0xC0000000, 0 over 4 periods (wrap), and o_mod upper bits follow.
REQ-036 The bench SHALL, with MOD_RAMP_EN, apply amp_h=32000 and o_ramp[31:16]=0x1000 -> required response: o_mod saturates at 32767.
